// File: rtl/fft_addr_sequencer.sv
// Self-sequencing address generator for an in-place radix-2 DIT FFT with ping-pong banks.
// Optional `FFT_ADDR_SEQ_STALL_EN adds i_stall, which freezes the whole sequence while high.
module fft_addr_sequencer #(
   parameter int LOG2_N     = 10,
   parameter int BF_LATENCY = 4
) (
   input  logic                      i_clk,
   input  logic                      i_rst_n,
   input  logic                      i_start,
`ifdef FFT_ADDR_SEQ_STALL_EN
   input  logic                      i_stall,
`endif
   output logic                      o_busy,
   output logic                      o_done,
   output logic [$clog2(LOG2_N)-1:0] o_stage,
   output logic                      o_rd_en,
   output logic                      o_rd_bank,
   output logic [LOG2_N-1:0]         o_rd_addr_a,
   output logic [LOG2_N-1:0]         o_rd_addr_b,
   output logic [LOG2_N-2:0]         o_tw_addr,
   output logic                      o_wr_en,
   output logic                      o_wr_bank,
   output logic [LOG2_N-1:0]         o_wr_addr_a,
   output logic [LOG2_N-1:0]         o_wr_addr_b,
   output logic [1:0]                o_dbg_state
);
   localparam int STG_W  = $clog2(LOG2_N);
   localparam int PAIR_W = LOG2_N - 1;
   localparam int TW_W   = LOG2_N - 1;
   localparam logic [STG_W-1:0]  STG_LAST   = STG_W'(LOG2_N - 1);
   localparam logic [PAIR_W-1:0] PAIR_LAST  = '1;
   localparam logic [4:0]        DRAIN_LAST = 5'(BF_LATENCY - 1);

   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2, FLUSH = 2'd3} state_t;

   typedef struct packed {
      logic              en;
      logic              bank;
      logic [LOG2_N-1:0] a;
      logic [LOG2_N-1:0] b;
      logic [TW_W-1:0]   tw;
      logic              last;
   } rd_t;

   typedef struct packed {
      logic              en;
      logic              bank;
      logic [LOG2_N-1:0] a;
      logic [LOG2_N-1:0] b;
      logic              last;
   } wr_t;

   state_t            state;
   logic [STG_W-1:0]  stage;
   logic [PAIR_W-1:0] pair;
   logic [PAIR_W-1:0] pair_inc;
   logic [4:0]        cnt;
   rd_t               rd_q;
   wr_t               pipe [BF_LATENCY];
   logic              hold;

   // Butterfly addresses: insert a zero at bit s of the pair index; b sets that bit.
   function automatic rd_t mk_rd(input logic [STG_W-1:0] s, input logic [PAIR_W-1:0] p,
                                 input logic last);
      rd_t               r;
      int                si;
      logic [LOG2_N-1:0] pw;
      logic [LOG2_N-1:0] span;
      logic [LOG2_N-1:0] lo;
      si     = int'(s);
      pw     = LOG2_N'(p);
      span   = LOG2_N'(1) << si;
      lo     = pw & (span - LOG2_N'(1));
      r.en   = 1'b1;
      r.bank = s[0];
      r.a    = ((pw >> si) << (si + 1)) | lo;
      r.b    = r.a | span;
      r.tw   = TW_W'(lo << (LOG2_N - 1 - si));
      r.last = last;
      return r;
   endfunction

`ifdef FFT_ADDR_SEQ_STALL_EN
   assign hold = i_stall & (state != IDLE);
`else
   assign hold = 1'b0;
`endif

   assign pair_inc = pair + PAIR_W'(1);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state <= IDLE;
         stage <= '0;
         pair  <= '0;
         cnt   <= '0;
         rd_q  <= '0;
         for (int i = 0; i < BF_LATENCY; i++) pipe[i] <= '0;
      end else if (!hold) begin
         // The write side is the read side replayed BF_LATENCY cycles later into the other bank.
         pipe[0] <= '{en: rd_q.en, bank: ~rd_q.bank, a: rd_q.a, b: rd_q.b,
                      last: rd_q.en & rd_q.last};
         for (int i = 1; i < BF_LATENCY; i++) pipe[i] <= pipe[i-1];
         unique case (state)
            IDLE: begin
               rd_q.en   <= 1'b0;
               rd_q.last <= 1'b0;
               if (i_start) begin
                  state <= RUN;
                  stage <= '0;
                  pair  <= '0;
                  rd_q  <= mk_rd('0, '0, 1'b0);
               end
            end
            RUN: begin
               if (pair == PAIR_LAST) begin
                  rd_q.en   <= 1'b0;
                  rd_q.last <= 1'b0;
                  if (stage == STG_LAST) begin
                     state <= FLUSH;
                  end else begin
                     state <= DRAIN;
                     cnt   <= '0;
                     stage <= stage + STG_W'(1);
                     pair  <= '0;
                  end
               end else begin
                  pair <= pair_inc;
                  rd_q <= mk_rd(stage, pair_inc, (stage == STG_LAST) && (pair_inc == PAIR_LAST));
               end
            end
            DRAIN: begin
               if (cnt == DRAIN_LAST) begin
                  state <= RUN;
                  rd_q  <= mk_rd(stage, pair, 1'b0);
               end else begin
                  cnt <= cnt + 5'd1;
               end
            end
            FLUSH: begin
               if (pipe[BF_LATENCY-1].last) state <= IDLE;
            end
         endcase
      end
   end

   assign o_busy      = (state != IDLE);
   assign o_done      = pipe[BF_LATENCY-1].last & ~hold;
   assign o_stage     = stage;
   assign o_rd_en     = rd_q.en & ~hold;
   assign o_rd_bank   = rd_q.bank;
   assign o_rd_addr_a = rd_q.a;
   assign o_rd_addr_b = rd_q.b;
   assign o_tw_addr   = rd_q.tw;
   assign o_wr_en     = pipe[BF_LATENCY-1].en & ~hold;
   assign o_wr_bank   = pipe[BF_LATENCY-1].bank;
   assign o_wr_addr_a = pipe[BF_LATENCY-1].a;
   assign o_wr_addr_b = pipe[BF_LATENCY-1].b;
   assign o_dbg_state = state;

endmodule

// File: tb/tb_fft_addr_sequencer.sv
// Bench for fft_addr_sequencer: an N=8/latency-2 instance and a default N=1024/latency-4 instance.
// Every cycle both are compared against a cycle-indexed model of the read/write schedule.
module tb_fft_addr_sequencer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   localparam int T_S = 18;  // busy cycles of the small instance
   localparam int P_S = 6;   // pairs per stage + drain cycles, small instance

   typedef struct packed {
      logic [1:0]  dbg;
      logic        busy;
      logic        done;
      logic        rd_en;
      logic        rd_bank;
      logic [3:0]  stage;
      logic [11:0] ra;
      logic [11:0] rb;
      logic [11:0] tw;
      logic        wr_en;
      logic        wr_bank;
      logic [11:0] wa;
      logic [11:0] wb;
   } obs_t;

   typedef struct {
      logic active;
      int   k;
   } mdl_t;

   typedef struct {
      int s;
      int a;
      int b;
      int tw;
      int bank;
   } vec_t;

   logic rst_s, start_s, stall_s, rst_d, start_d, stall_d;
   logic       s_busy, s_done, s_rd_en, s_rd_bank, s_wr_en, s_wr_bank;
   logic [1:0] s_stage, s_tw, s_dbg;
   logic [2:0] s_ra, s_rb, s_wa, s_wb;
   logic       d_busy, d_done, d_rd_en, d_rd_bank, d_wr_en, d_wr_bank;
   logic [3:0] d_stage;
   logic [8:0] d_tw;
   logic [1:0] d_dbg;
   logic [9:0] d_ra, d_rb, d_wa, d_wb;

   fft_addr_sequencer #(.LOG2_N(3), .BF_LATENCY(2)) dut_s (
      .i_clk(clk), .i_rst_n(rst_s), .i_start(start_s),
`ifdef FFT_ADDR_SEQ_STALL_EN
      .i_stall(stall_s),
`endif
      .o_busy(s_busy), .o_done(s_done), .o_stage(s_stage), .o_rd_en(s_rd_en),
      .o_rd_bank(s_rd_bank), .o_rd_addr_a(s_ra), .o_rd_addr_b(s_rb), .o_tw_addr(s_tw),
      .o_wr_en(s_wr_en), .o_wr_bank(s_wr_bank), .o_wr_addr_a(s_wa), .o_wr_addr_b(s_wb),
      .o_dbg_state(s_dbg)
   );

   fft_addr_sequencer dut_d (
      .i_clk(clk), .i_rst_n(rst_d), .i_start(start_d),
`ifdef FFT_ADDR_SEQ_STALL_EN
      .i_stall(stall_d),
`endif
      .o_busy(d_busy), .o_done(d_done), .o_stage(d_stage), .o_rd_en(d_rd_en),
      .o_rd_bank(d_rd_bank), .o_rd_addr_a(d_ra), .o_rd_addr_b(d_rb), .o_tw_addr(d_tw),
      .o_wr_en(d_wr_en), .o_wr_bank(d_wr_bank), .o_wr_addr_a(d_wa), .o_wr_addr_b(d_wb),
      .o_dbg_state(d_dbg)
   );

   obs_t obs_s, obs_d;
   obs_t zero_o;

   always_comb begin
      obs_s = '0;
      obs_s.dbg = s_dbg; obs_s.busy = s_busy; obs_s.done = s_done;
      obs_s.rd_en = s_rd_en; obs_s.rd_bank = s_rd_bank; obs_s.stage = 4'(s_stage);
      obs_s.ra = 12'(s_ra); obs_s.rb = 12'(s_rb); obs_s.tw = 12'(s_tw);
      obs_s.wr_en = s_wr_en; obs_s.wr_bank = s_wr_bank; obs_s.wa = 12'(s_wa); obs_s.wb = 12'(s_wb);
      obs_d = '0;
      obs_d.dbg = d_dbg; obs_d.busy = d_busy; obs_d.done = d_done;
      obs_d.rd_en = d_rd_en; obs_d.rd_bank = d_rd_bank; obs_d.stage = d_stage;
      obs_d.ra = 12'(d_ra); obs_d.rb = 12'(d_rb); obs_d.tw = 12'(d_tw);
      obs_d.wr_en = d_wr_en; obs_d.wr_bank = d_wr_bank; obs_d.wa = 12'(d_wa); obs_d.wb = 12'(d_wb);
   end

   int   n_vec = 0;
   int   n_bad = 0;
   int   cyc = 0;
   logic chk_on = 1'b0;
   logic cap_on = 1'b0;
   mdl_t m_s, m_d;
   int   first_rd_s, done_cyc_s, busy_cnt_s, ndone_s;
   int   first_rd_d, done_cyc_d, busy_cnt_d, ndone_d, rd_cnt_d;
   int   rec_d [4];
   logic [47:0] exp_q [$];
   vec_t tbl [12];

   // Index of pair p within stage span: pairs fill blocks of 2*span, lower half of each block.
   function automatic int slot(input int p, input int span);
      return (p / span) * 2 * span + (p % span);
   endfunction

   function automatic obs_t model_exp(input int lg, input int lat, input mdl_t m, input logic stall);
      obs_t e;
      int half, per, s, p, kw, span;
      e = '0;
      half = 1 << (lg - 1);
      per  = half + lat;
      e.busy = m.active;
      if (m.active && !stall) begin
         if (m.k / per < lg && m.k % per < half) begin
            s = m.k / per; p = m.k % per; span = 1 << s;
            e.rd_en = 1'b1; e.stage = 4'(s); e.rd_bank = (s % 2) == 1;
            e.ra = 12'(slot(p, span)); e.rb = 12'(slot(p, span) + span);
            e.tw = 12'((p % span) * (half / span));
         end
         kw = m.k - lat;
         if (kw >= 0 && kw / per < lg && kw % per < half) begin
            s = kw / per; p = kw % per; span = 1 << s;
            e.wr_en = 1'b1; e.wr_bank = (s % 2) == 0;
            e.wa = 12'(slot(p, span)); e.wb = 12'(slot(p, span) + span);
         end
         e.done = (m.k == lg * per - 1);
      end
      return e;
   endfunction

   function automatic mdl_t next_model(input int lg, input int lat, input mdl_t m,
                                       input logic rst, input logic stall, input logic start);
      mdl_t r;
      int tot;
      r = m;
      tot = lg * ((1 << (lg - 1)) + lat);
      if (!rst) begin
         r.active = 1'b0; r.k = 0;
      end else if (m.active) begin
         if (!stall) begin
            if (m.k == tot - 1) r.active = 1'b0;
            else r.k = m.k + 1;
         end
      end else if (start) begin
         r.active = 1'b1; r.k = 0;
      end
      return r;
   endfunction

   function automatic obs_t mask(input obs_t o);
      obs_t r;
      r = o;
      r.dbg = '0;
      if (!r.rd_en) begin r.rd_bank = 0; r.stage = 0; r.ra = 0; r.rb = 0; r.tw = 0; end
      if (!r.wr_en) begin r.wr_bank = 0; r.wa = 0; r.wb = 0; end
      return r;
   endfunction

   task automatic cmp(input string nm, input obs_t got, input obs_t exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s cycle %0d got=%h exp=%h", nm, cyc, got, exp);
      end
   endtask

   task automatic chk_int(input string nm, input int got, input int exp);
      n_vec++;
      if (got != exp) begin
         n_bad++;
         $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
      end
   endtask

   // Per-cycle scoreboard, sampled mid-cycle.
   always @(negedge clk) begin
      logic [47:0] got, ev;
      if (chk_on) begin
         cyc++;
         if (!rst_s) cmp("small_reset", obs_s, zero_o);
         else cmp("small_seq", mask(obs_s), model_exp(3, 2, m_s, stall_s));
         if (!rst_d) cmp("dflt_reset", obs_d, zero_o);
         else cmp("dflt_seq", mask(obs_d), model_exp(10, 4, m_d, stall_d));
         m_s = next_model(3, 2, m_s, rst_s, stall_s, start_s);
         m_d = next_model(10, 4, m_d, rst_d, stall_d, start_d);
         if (s_rd_en && first_rd_s < 0) first_rd_s = cyc;
         if (s_busy) busy_cnt_s++;
         if (s_done) begin done_cyc_s = cyc; ndone_s++; end
         if (d_rd_en && first_rd_d < 0) first_rd_d = cyc;
         if (d_busy) busy_cnt_d++;
         if (d_done) begin done_cyc_d = cyc; ndone_d++; end
         if (d_rd_en) begin
            if (rd_cnt_d == 9 * 512 + 1) rec_d = '{int'(d_stage), int'(d_ra), int'(d_rb), int'(d_tw)};
            rd_cnt_d++;
         end
         if (cap_on && s_rd_en) begin
            got = {8'(s_stage), 12'(s_ra), 12'(s_rb), 12'(s_tw), 4'(s_rd_bank)};
            n_vec++;
            if (exp_q.size() == 0) begin
               n_bad++;
               $display("FAIL tbl_extra_read got=%h", got);
            end else begin
               ev = exp_q.pop_front();
               if (got !== ev) begin
                  n_bad++;
                  $display("FAIL tbl_read got=%h exp=%h", got, ev);
               end
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_s();
      first_rd_s = -1; done_cyc_s = -1; busy_cnt_s = 0; ndone_s = 0;
   endtask

   task automatic pulse_start_s();
      start_s = 1'b1;
      tick();
      start_s = 1'b0;
      tick();
   endtask

   task automatic wait_idle_s(input int bound);
      int n;
      n = 0;
      while (m_s.active && n < bound) begin
         tick();
         n++;
      end
   endtask

   initial begin
      int n;
      logic s1, s2;
      rst_s = 0; rst_d = 0; start_s = 0; start_d = 0; stall_s = 0; stall_d = 0;
      zero_o = '0;
      m_s = '{1'b0, 0}; m_d = '{1'b0, 0};
      clear_s();
      first_rd_d = -1; done_cyc_d = -1; busy_cnt_d = 0; ndone_d = 0; rd_cnt_d = 0;
      rec_d = '{-1, -1, -1, -1};
      tbl = '{'{0, 0, 1, 0, 0}, '{0, 2, 3, 0, 0}, '{0, 4, 5, 0, 0}, '{0, 6, 7, 0, 0},
              '{1, 0, 2, 0, 1}, '{1, 1, 3, 2, 1}, '{1, 4, 6, 0, 1}, '{1, 5, 7, 2, 1},
              '{2, 0, 4, 0, 0}, '{2, 1, 5, 1, 0}, '{2, 2, 6, 2, 0}, '{2, 3, 7, 3, 0}};

      tick();
      chk_on = 1'b1;
      tick(); tick(); tick();
      rst_s = 1; rst_d = 1;
      tick(); tick();

      // Reference run against the hand-derived N=8 address table
      for (int i = 0; i < 12; i++)
         exp_q.push_back({8'(tbl[i].s), 12'(tbl[i].a), 12'(tbl[i].b), 12'(tbl[i].tw), 4'(tbl[i].bank)});
      clear_s();
      cap_on = 1'b1;
      pulse_start_s();
      wait_idle_s(200);
      tick();
      cap_on = 1'b0;
      chk_int("tbl_leftover", exp_q.size(), 0);
      chk_int("small_done_latency", done_cyc_s - first_rd_s, 17);
      chk_int("small_busy_cycles", busy_cnt_s, T_S);
      chk_int("small_done_count", ndone_s, 1);

      // Start pulses mid-run and in the o_done cycle must be ignored
      clear_s();
      pulse_start_s();
      n = 0;
      while (m_s.active && n < 200) begin
         start_s = (m_s.k == 5) || (m_s.k == T_S - 1);
         tick();
         n++;
      end
      start_s = 1'b0;
      tick(); tick(); tick();
      chk_int("restart_done_count", ndone_s, 1);
      chk_int("restart_done_latency", done_cyc_s - first_rd_s, 17);

      // Asynchronous reset during stage 1, then a clean restart
      pulse_start_s();
      n = 0;
      while (m_s.k != P_S + 1 && n < 100) begin tick(); n++; end
      rst_s = 1'b0;
      tick(); tick();
      rst_s = 1'b1;
      tick();
      clear_s();
      pulse_start_s();
      wait_idle_s(200);
      tick();
      chk_int("post_reset_done_latency", done_cyc_s - first_rd_s, 17);
      chk_int("post_reset_done_count", ndone_s, 1);

`ifdef FFT_ADDR_SEQ_STALL_EN
      // 3 stalled cycles in stage 1 plus 2 in the following drain
      clear_s();
      pulse_start_s();
      s1 = 1'b0; s2 = 1'b0; n = 0;
      while (m_s.active && n < 300) begin
         if (!s1 && m_s.k == P_S + 1) begin
            stall_s = 1'b1; tick(); tick(); tick(); stall_s = 1'b0; s1 = 1'b1;
         end else if (!s2 && m_s.k == P_S + 4) begin
            stall_s = 1'b1; tick(); tick(); stall_s = 1'b0; s2 = 1'b1;
         end else begin
            tick();
         end
         n++;
      end
      tick();
      chk_int("stall_done_latency", done_cyc_s - first_rd_s, 22);
      chk_int("stall_busy_cycles", busy_cnt_s, T_S + 5);
      chk_int("stall_done_count", ndone_s, 1);
`else
      s1 = 1'b0; s2 = 1'b0;
`endif

      // Random start pulses (and random stalls when the stall input exists)
      for (int i = 0; i < 400; i++) begin
         start_s = ($urandom_range(0, 7) == 0);
`ifdef FFT_ADDR_SEQ_STALL_EN
         stall_s = ($urandom_range(0, 3) == 0);
`endif
         tick();
      end
      start_s = 1'b0; stall_s = 1'b0;
      wait_idle_s(200);
      tick(); tick();

      // Default configuration: N=1024, BF_LATENCY=4
      start_d = 1'b1;
      tick();
      start_d = 1'b0;
      n = 0;
      while (m_d.active && n < 7000) begin tick(); n++; end
      tick(); tick();
      chk_int("dflt_done_latency", done_cyc_d - first_rd_d, 5159);
      chk_int("dflt_busy_cycles", busy_cnt_d, 5160);
      chk_int("dflt_done_count", ndone_d, 1);
      chk_int("dflt_s9p1_stage", rec_d[0], 9);
      chk_int("dflt_s9p1_a", rec_d[1], 1);
      chk_int("dflt_s9p1_b", rec_d[2], 513);
      chk_int("dflt_s9p1_tw", rec_d[3], 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
